mux_n_to_1_reg: RTL and testbench

- Parametrised N-input, WIDTH-bit selector with a registered output and a valid/ready handshake; the pipelined successor to the combinational 16-bit 2:1 datapath muxes.
- Sits between pipeline stages for operand, writeback and PC-source selection.
- Includes a 2-entry skid buffer, so out_ready back-pressure never combinationally reaches in_ready.

---
 rtl/mux_n_to_1_reg_pkg.sv | 6 +
 rtl/mux_n_to_1_comb.sv | 25 ++
 rtl/mux_n_to_1_reg.sv | 75 +++++++
 tb/tb_mux_n_to_1_reg.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_n_to_1_reg_pkg.sv
// Common word-size definition shared by the registered selector family.
package mux_n_to_1_reg_pkg;

  localparam int WORD_W = 16;

endpackage

// File: rtl/mux_n_to_1_comb.sv
// Purely combinational N_IN-way word select with an out-of-range error flag.
module mux_n_to_1_comb #(
  parameter  int WIDTH = 16,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      word,
  output logic                  err
);

  // Unmatched select codes (non-power-of-2 N_IN) fall back to a zero word with err set.
  always_comb begin
    word = '0;
    err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = in_data[k*WIDTH +: WIDTH];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n_to_1_reg.sv
// Registered N:1 word selector with valid/ready handshake and a 2-entry skid buffer.
module mux_n_to_1_reg
  import mux_n_to_1_reg_pkg::*;
#(
  parameter  int WIDTH = WORD_W,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  logic [WIDTH-1:0] sel_word;
  logic             sel_word_err;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             skid_valid;
  logic             accept;
  logic             drain;

  mux_n_to_1_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .word    (sel_word),
    .err     (sel_word_err)
  );

  // in_ready comes straight from a register, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;

  // Stage boundary: output register plus skid register.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      sel_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (accept) begin
      if (!out_valid || drain) begin
        out_valid <= 1'b1;
        out_data  <= sel_word;
        sel_err   <= sel_word_err;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= sel_word;
        skid_err   <= sel_word_err;
      end
    end else if (drain) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        sel_err    <= skid_err;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Directed and random checks of mux_n_to_1_reg against a queue scoreboard.
module tb_mux_n_to_1_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic [47:0] in_data3;
  logic [1:0]  sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [15:0] out_data3;
  logic        out_valid3;
  logic        out_ready3;
  logic        sel_err3;
  logic        flush3;

  int checks = 0;
  int errors = 0;

  logic [16:0] sb[$];
  logic        hold_pend = 1'b0;
  logic [15:0] hold_data;
  logic        hold_err;

  always #5 clk = ~clk;

  mux_n_to_1_reg #(.WIDTH(16), .N_IN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  mux_n_to_1_reg #(.WIDTH(16), .N_IN(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .flush     (flush3),
    .out_data  (out_data3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .sel_err   (sel_err3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [63:0] d, input int s, input int n);
    if (s >= n) return {1'b1, 16'h0000};
    return {1'b0, d[s*16 +: 16]};
  endfunction

  // One clock of the 4-input DUT: inputs are held, outputs judged at the falling edge.
  task automatic cycle();
    logic        acc;
    logic        drn;
    logic [16:0] e;
    @(negedge clk);
    if (hold_pend) begin
      chk("stable_vld", out_valid, 1);
      chk("stable_data", out_data, hold_data);
      chk("stable_err", sel_err, hold_err);
    end
    acc = (in_valid === 1'b1) && (in_ready === 1'b1) && !rst && !flush;
    drn = (out_valid === 1'b1) && out_ready && !rst && !flush;
    if (drn) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_data, e[15:0]);
        chk("sb_err", sel_err, e[16]);
      end
    end
    if (rst || flush) sb.delete();
    else if (acc) sb.push_back(model(in_data, int'(sel), 4));
    hold_pend = (out_valid === 1'b1) && !out_ready && !rst && !flush;
    hold_data = out_data;
    hold_err  = sel_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; sel = 2'd0; out_ready = 1'b0;
    in_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    in_data3 = {16'h3333, 16'h2222, 16'h1111};
    sel3 = 2'd0; in_valid3 = 1'b1; out_ready3 = 1'b1; flush3 = 1'b0;

    // Reset held two cycles with in_valid high
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sel_err", sel_err, 0);
      chk("rst3_out_valid", out_valid3, 0);
    end
    rst = 1'b0; in_valid = 1'b0; in_valid3 = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    cycle();
    chk("idle_out_valid", out_valid, 0);

    // Streaming, out_ready high, no bubbles
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      if (i > 0) chk("stream_vld", out_valid, 1);
      cycle();
    end
    in_valid = 1'b0;
    chk("stream_vld", out_valid, 1);
    chk("stream_last", out_data, 16'h4444);
    cycle();
    chk("stream_idle", out_valid, 0);

    // Back-pressure into the skid register
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
    cycle();
    sel = 2'd3;
    chk("bp_in_ready2", in_ready, 1);
    cycle();
    sel = 2'd0;
    chk("bp_in_ready3", in_ready, 0);
    chk("bp_hold", out_data, 16'h3333);
    cycle();
    chk("bp_in_ready4", in_ready, 0);
    out_ready = 1'b1; in_valid = 1'b0;
    cycle();
    chk("bp_ready_back", in_ready, 1);
    chk("bp_second", out_data, 16'h4444);
    cycle();
    cycle();
    chk("bp_idle", out_valid, 0);

    // Flush with both registers full
    in_data = {16'h4444, 16'h3333, 16'hBBBB, 16'hAAAA};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    cycle();
    sel = 2'd1;
    cycle();
    chk("fl_full", in_ready, 0);
    flush = 1'b1; sel = 2'd2;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("fl_nothing", out_valid, 0);
    end

    // Out-of-range select on the 3-input instance
    in_valid3 = 1'b1; sel3 = 2'd3;
    @(posedge clk); #1;
    chk("oor_valid", out_valid3, 1);
    chk("oor_data", out_data3, 16'h0000);
    chk("oor_err", sel_err3, 1);
    sel3 = 2'd0;
    @(posedge clk); #1;
    chk("oor_next_data", out_data3, 16'h1111);
    chk("oor_next_err", sel_err3, 0);
    sel3 = 2'd2;
    @(posedge clk); #1;
    chk("oor_top_data", out_data3, 16'h3333);
    chk("oor_top_err", sel_err3, 0);
    in_valid3 = 1'b0;

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom};
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (sb.size() != 0) cycle();
    end
    chk("rand_drained", sb.size(), 0);
    cycle();
    chk("rand_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
